acc_out_port: RTL and testbench
===============================

ACC_OUT_PORT -- requirements
Module: acc_out_port

Interface
REQ-001 Parameter DEPTH, default 2, number of buffer entries; SHALL be a power of two, 2 to 16.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 CLB  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 acc_in  input  8  accumulator value to transmit.
REQ-005 cin  input  1  carry flag travelling with acc_in.
REQ-006 zin  input  1  zero flag travelling with acc_in.
REQ-007 OutEn  input  1  controller strobe: push {cin, zin, acc_in} on this edge.
REQ-008 port_ack  input  1  external sink accepts the head entry.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 port_data  output  8  head-entry data.
REQ-011 port_cout  output  1  head-entry carry flag.
REQ-012 port_zout  output  1  head-entry zero flag.
REQ-013 port_valid  output  1  head entry present.
REQ-014 full  output  1  count == DEPTH; controller SHALL stall OUT instructions while high.
REQ-015 ovf  output  1  sticky: a push was dropped.
REQ-016 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage: DEPTH-entry circular FIFO of 10-bit words {c, z, data[7:0]}, write and read pointers each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 port_data, port_cout, port_zout SHALL be registered head-entry values; when empty they SHALL hold the last value popped (0 after reset).
REQ-019 port_valid SHALL equal (count != 0); full SHALL equal (count == DEPTH); both purely from registered count.
REQ-020 Transfer: a pop occurs on an edge where port_valid and port_ack are both 1; port_ack while port_valid=0 SHALL be ignored.
REQ-021 Push accepted on an edge where OutEn=1 and (full=0 or a pop occurs on that same edge).
REQ-022 Latency: an entry pushed into an empty FIFO SHALL appear on port_data with port_valid=1 one cycle after the OutEn edge, no bypass.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance; when count==1, new entry SHALL become head next cycle.
REQ-024 OutEn while full with no pop: push dropped, FIFO contents and pointers unchanged, ovf set to 1 on that edge.
REQ-025 ovf SHALL stay 1 until an edge with ovf_clr=1; if ovf_clr and a dropped push coincide, ovf SHALL be 1 (set wins).
REQ-026 Order: entries SHALL leave in push order; port_valid SHALL not drop while count>0, and head data SHALL be stable while port_valid=1 and port_ack=0.
REQ-027 count SHALL never exceed DEPTH nor underflow below 0 under any input sequence.

Reset
REQ-028 CLB=0 SHALL immediately (no clock) force count=0, pointers=0, port_valid=0, full=0, ovf=0, port_data=0, port_cout=0, port_zout=0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; no entry pushed before reset SHALL appear afterwards.
REQ-030 First push SHALL be accepted on the first rising edge after CLB deasserts; storage array contents need not be reset.

Verification
REQ-031 Reset: CLB=0 mid-cycle with count=2 -> all outputs 0 before next edge; after release, port_valid=0.
REQ-032 Single transfer: OutEn with acc_in=8'hA5, cin=1, zin=0 -> next cycle port_valid=1, port_data=8'hA5, port_cout=1, port_zout=0; port_ack=1 -> next cycle port_valid=0, count=0.
REQ-033 Fill and drop (DEPTH=2): push 8'h11, 8'h22, 8'h33 with port_ack=0 -> full=1, ovf=1, outputs 8'h11 then 8'h22 on acks; 8'h33 never appears.
REQ-034 Full with simultaneous push/pop: count=2, OutEn with 8'h44 and port_ack=1 -> ovf stays 0, count stays 2, output sequence 8'h22, 8'h44.
REQ-035 Wrap-around: 10 push-one/pop-one cycles with values 0..9 -> all 10 values delivered in order, pointers wrapped, count=0 at end.
REQ-036 ovf priority: ovf=1, ovf_clr=1 on an edge with a dropped push -> ovf=1; ovf_clr alone next edge -> ovf=0.

Source files
------------

// File: rtl/acc_out_port_if.sv
// Bus between the accumulator controller and the output port buffer.
// Valid/ready: the head entry moves on a rising edge where port_valid and
// port_ack are both high. port_ack while port_valid is low does nothing.
// OutEn is a one-cycle push strobe. It is accepted when full is low, or when
// a pop happens on the same edge.
interface acc_out_port_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    acc_in;
    logic          cin;
    logic          zin;
    logic          OutEn;
    logic          port_ack;
    logic          ovf_clr;
    logic [7:0]    port_data;
    logic          port_cout;
    logic          port_zout;
    logic          port_valid;
    logic          full;
    logic          ovf;
    logic [CW-1:0] count;

    // Controller / sink side: drives the push, ack and clear inputs.
    modport master (
        output acc_in, cin, zin, OutEn, port_ack, ovf_clr,
        input  port_data, port_cout, port_zout, port_valid, full, ovf, count
    );

    // Buffer side.
    modport slave (
        input  acc_in, cin, zin, OutEn, port_ack, ovf_clr,
        output port_data, port_cout, port_zout, port_valid, full, ovf, count
    );
endinterface

// File: rtl/acc_out_port.sv
// Output port buffer: a DEPTH-entry circular FIFO of {carry, zero, data}
// words. The head entry is presented on registered outputs.
// DEPTH must be a power of two from 2 to 16. The pointers rely on natural
// binary wrap, so other values are not supported.
module acc_out_port #(
    parameter int DEPTH = 2
) (
    input  logic           CLK,
    input  logic           CLB,
    acc_out_port_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]    head_q, head_d;
    logic          ovf_q, ovf_d;

    logic          valid;
    logic          is_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [9:0]    wdata;

    assign valid   = (count_q != '0);
    assign is_full = (count_q == CW'(DEPTH));
    assign pop     = valid && bus.port_ack;
    assign push    = bus.OutEn && (!is_full || pop);
    assign drop    = bus.OutEn && is_full && !pop;
    assign wdata   = {bus.cin, bus.zin, bus.acc_in};

    // Next pointers, occupancy and sticky overflow (a dropped push beats a clear).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Next head register. It keeps the last popped word while the FIFO is empty.
    // It takes the word being written when the new head slot is filled on this
    // same edge. That happens on a push into an empty FIFO, or on a push plus
    // pop at count 1.
    always_comb begin
        head_d = head_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wdata;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Storage array; its contents need no reset because count gates all reads.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Control state; reset empties the FIFO and clears the presented head.
    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.port_data  = head_q[7:0];
    assign bus.port_zout  = head_q[8];
    assign bus.port_cout  = head_q[9];
    assign bus.port_valid = valid;
    assign bus.full       = is_full;
    assign bus.ovf        = ovf_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_acc_out_port.sv
// Self-checking bench for acc_out_port with DEPTH = 2.
module tb_acc_out_port;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;

  acc_out_port_if #(.DEPTH(DEPTH)) bus ();

  acc_out_port #(.DEPTH(DEPTH)) dut (
    .CLK (clk),
    .CLB (rst_n),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  logic [9:0] exp_q[$];
  int         m_count;
  logic [9:0] m_last;
  logic       m_ovf;
  int         n_checks;
  int         n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_last  = '0;
    m_ovf   = 1'b0;
  endtask

  // Compare all outputs against the model; called away from the rising edge.
  task automatic check_outputs(input string tag);
    logic [9:0] head;
    head = (m_count != 0) ? exp_q[0] : m_last;
    check({tag, ".valid"}, 32'(bus.port_valid), 32'(m_count != 0));
    check({tag, ".full"},  32'(bus.full),       32'(m_count == DEPTH));
    check({tag, ".count"}, 32'(bus.count),      32'(m_count));
    check({tag, ".ovf"},   32'(bus.ovf),        32'(m_ovf));
    check({tag, ".head"},  32'({bus.port_cout, bus.port_zout, bus.port_data}), 32'(head));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. It drives one cycle of inputs, applies
  // the model on the rising edge, then checks at the next falling edge.
  task automatic step(input string tag, input logic oe, input logic [7:0] d,
                      input logic c, input logic z, input logic ack, input logic clr);
    logic pop;
    logic acc;
    bus.OutEn    = oe;
    bus.acc_in   = d;
    bus.cin      = c;
    bus.zin      = z;
    bus.port_ack = ack;
    bus.ovf_clr  = clr;
    @(posedge clk);
    pop = (m_count != 0) && ack;
    acc = oe && ((m_count != DEPTH) || pop);
    if (pop) begin
      m_last = exp_q.pop_front();
      m_count--;
    end
    if (acc) begin
      exp_q.push_back({c, z, d});
      m_count++;
    end
    if (oe && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    bus.OutEn    = 1'b0;
    bus.acc_in   = '0;
    bus.cin      = 1'b0;
    bus.zin      = 1'b0;
    bus.port_ack = 1'b0;
    bus.ovf_clr  = 1'b0;
  endtask

  // Assert reset between edges and verify the outputs clear with no clock.
  task automatic mid_cycle_reset(input string tag);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_valid"}, 32'(bus.port_valid), 32'(0));
    check({tag, ".rst_full"},  32'(bus.full),       32'(0));
    check({tag, ".rst_count"}, 32'(bus.count),      32'(0));
    check({tag, ".rst_ovf"},   32'(bus.ovf),        32'(0));
    check({tag, ".rst_head"},  32'({bus.port_cout, bus.port_zout, bus.port_data}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs({tag, ".released"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Single transfer; the first push lands on the first edge after release.
    step("single_push", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("single_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step("single_pop",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Fill and drop: 8'h33 is lost and ovf sets.
    step("fill_11",  1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fill_22",  1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    step("drop_33",  1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    step("ovf_clr",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous push and pop: no overflow, count stays 2.
    step("full_pp",  1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
    step("drain_22", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("drain_44", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("ack_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow priority: a set on the same edge as a clear wins.
    step("pri_a",    1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pri_b",    1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("pri_drop", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    step("pri_both", 1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 1'b1);
    step("pri_clr",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step("pri_d1",   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step("pri_d2",   1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Wrap-around: push-one/pop-one with values 0..9.
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step("wrap_end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("wrap_count0", 32'(bus.count), 32'(0));

    // Reset while two entries are held; none of them may reappear.
    step("prerst_a", 1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("prerst_b", 1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0);
    mid_cycle_reset("midrst");
    step("postrst_push", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    step("postrst_pop",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      step("final_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
